// File: rtl/dot_clock_gen.sv
// dot_clock_gen: derives the pixel dot clock and a one-cycle dot enable from the
// board oscillator. The default build is an integer divide-by-DIV_N. Define the
// macro DOTCLK_FRAC_EN to build instead a FRAC_W-bit phase-accumulator divider
// that steps by FRAC_INC per board edge.
// Both outputs are driven directly from flops, so they are glitch-free.
module dot_clock_gen #(
   parameter int unsigned DIV_N    = 2,
   parameter int unsigned FRAC_W   = 16,
   parameter int unsigned FRAC_INC = 32768
) (
   input  logic board,
   input  logic rst_n,
   output logic dotclock,
   output logic dot_en
);

   if (DIV_N < 2 || DIV_N > 1024) begin : g_bad_div
      $error("dot_clock_gen: DIV_N=%0d is outside 2..1024", DIV_N);
   end

   logic r_dotclock;
   logic r_dot_en;

`ifdef DOTCLK_FRAC_EN

   if (FRAC_W < 2 || FRAC_W > 32) begin : g_bad_frac_w
      $error("dot_clock_gen: FRAC_W=%0d is outside 2..32", FRAC_W);
   end
   if (FRAC_INC < 1 || 64'(FRAC_INC) > (64'd1 << (FRAC_W - 1))) begin : g_bad_frac_inc
      $error("dot_clock_gen: FRAC_INC=%0d is outside 1..2^(FRAC_W-1)", FRAC_INC);
   end

   localparam logic [FRAC_W-1:0] FracStep = FRAC_W'(FRAC_INC);

   logic [FRAC_W-1:0] r_acc;
   logic [FRAC_W-1:0] w_acc_next;

   // Phase accumulator next value; wraps modulo 2^FRAC_W.
   always_comb begin
      w_acc_next = r_acc + FracStep;
   end

   // The accumulator MSB is the dot clock. The enable marks its 0->1 transition.
   always_ff @(posedge board or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_dotclock <= 1'b0;
         r_dot_en   <= 1'b0;
      end else begin
         r_acc      <= w_acc_next;
         r_dotclock <= w_acc_next[FRAC_W-1];
         r_dot_en   <= w_acc_next[FRAC_W-1] & ~r_acc[FRAC_W-1];
      end
   end

`else

   localparam int unsigned     CntW       = $clog2(DIV_N);
   localparam int unsigned     HighCycles = (DIV_N + 1) / 2;
   localparam logic [CntW-1:0] CntLast    = CntW'(DIV_N - 1);
   localparam logic [CntW-1:0] CntHigh    = CntW'(HighCycles);

   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_next;
   logic            w_high;
   logic            w_start;

   // Next count with wrap at DIV_N-1, plus the decodes of the pre-edge count.
   always_comb begin
      w_cnt_next = r_cnt + 1'b1;
      if (r_cnt == CntLast) begin
         w_cnt_next = '0;
      end
      w_high  = (r_cnt < CntHigh);
      w_start = (r_cnt == '0);
   end

   // Count register and output flops. The outputs are decoded from the pre-edge count.
   always_ff @(posedge board or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_dotclock <= 1'b0;
         r_dot_en   <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_dotclock <= w_high;
         r_dot_en   <= w_start;
      end
   end

`endif

   assign dotclock = r_dotclock;
   assign dot_en   = r_dot_en;

endmodule

// File: tb/tb_dot_clock_gen.sv
// tb_dot_clock_gen: drives several integer-mode dividers from one board clock and one
// reset, and checks them against fixed vectors and against an edge-count reference.
module tb_dot_clock_gen;

   localparam int unsigned NInst = 6;
   localparam int unsigned NS [NInst] = '{2, 3, 4, 5, 7, 1024};

   logic             board = 1'b0;
   logic             rst_n = 1'b0;
   logic [NInst-1:0] w_dc;
   logic [NInst-1:0] w_en;

   int n_chk = 0;
   int n_err = 0;
   int unsigned k_edges = 0;

   for (genvar gi = 0; gi < NInst; gi++) begin : g_dut
      dot_clock_gen #(.DIV_N(NS[gi])) u_dut (
         .board   (board),
         .rst_n   (rst_n),
         .dotclock(w_dc[gi]),
         .dot_en  (w_en[gi])
      );
   end

   always #5 board = ~board;

   // Reference: count the rising board edges seen with reset released.
   always @(posedge board or negedge rst_n) begin
      if (!rst_n) k_edges <= 0;
      else        k_edges <= k_edges + 1;
   end

   // After edge k, dotclock is high for the first ceil(n/2) edges of each group of n edges.
   function automatic logic model_dc(int unsigned n, int unsigned k);
      if (k == 0) return 1'b0;
      return ((k - 1) % n) < ((n + 1) / 2);
   endfunction

   function automatic logic model_en(int unsigned n, int unsigned k);
      if (k == 0) return 1'b0;
      return ((k - 1) % n) == 0;
   endfunction

   task automatic check(input string name, input logic [NInst-1:0] got,
                        input logic [NInst-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, got, exp);
      end
   endtask

   task automatic check_model(input string name);
      logic [NInst-1:0] edc;
      logic [NInst-1:0] een;
      for (int i = 0; i < NInst; i++) begin
         edc[i] = model_dc(NS[i], k_edges);
         een[i] = model_en(NS[i], k_edges);
      end
      check({name, "_dotclock"}, w_dc, edc);
      check({name, "_dot_en"}, w_en, een);
   endtask

   // Each bit is an instance: bit0=DIV_N 2, then 3, 4, 5, 7, and bit5=DIV_N 1024.
   typedef struct {
      logic             rst_n;
      logic [NInst-1:0] dc;
      logic [NInst-1:0] en;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic seq4_dc [4];
      logic seq4_en [4];
      int   n_rise;
      int   n_pulse2;
      int   n_pulse5;
      logic prev_dc;

      vecs[0]  = '{1'b0, 6'b000000, 6'b000000};
      vecs[1]  = '{1'b1, 6'b111111, 6'b111111};
      vecs[2]  = '{1'b1, 6'b111110, 6'b000000};
      vecs[3]  = '{1'b1, 6'b111001, 6'b000001};
      vecs[4]  = '{1'b1, 6'b110010, 6'b000010};
      vecs[5]  = '{1'b1, 6'b100111, 6'b000101};
      vecs[6]  = '{1'b1, 6'b101100, 6'b001000};
      vecs[7]  = '{1'b1, 6'b101011, 6'b000011};
      vecs[8]  = '{1'b1, 6'b111010, 6'b010000};
      vecs[9]  = '{1'b1, 6'b110101, 6'b000101};
      vecs[10] = '{1'b1, 6'b110110, 6'b000010};
      seq4_dc = '{1'b1, 1'b1, 1'b0, 1'b0};
      seq4_en = '{1'b1, 1'b0, 1'b0, 1'b0};

      #1;
      check("reset_dotclock", w_dc, '0);
      check("reset_dot_en", w_en, '0);

      // Fixed vectors: one row per board edge, starting from reset.
      for (int r = 0; r < 11; r++) begin
         @(negedge board);
         rst_n = vecs[r].rst_n;
         @(posedge board);
         #1;
         check($sformatf("vec%0d_dotclock", r), w_dc, vecs[r].dc);
         check($sformatf("vec%0d_dot_en", r), w_en, vecs[r].en);
      end

      // DIV_N=4 is now in its high phase. Reset must clear the outputs before any edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_dotclock", w_dc, '0);
      check("async_reset_dot_en", w_en, '0);
      repeat (2) @(posedge board);
      #1;
      check("held_reset_dotclock", w_dc, '0);
      // Release between edges. Nothing may change until the next rising edge.
      #1;
      rst_n = 1'b1;
      #2;
      check("release_no_edge_dotclock", w_dc, '0);
      check("release_no_edge_dot_en", w_en, '0);
      for (int j = 0; j < 4; j++) begin
         @(posedge board);
         #1;
         check($sformatf("restart4_dc%0d", j), NInst'(w_dc[2]), NInst'(seq4_dc[j]));
         check($sformatf("restart4_en%0d", j), NInst'(w_en[2]), NInst'(seq4_en[j]));
         check_model("restart");
      end

      // Random asynchronous reset assertions and releases, checked after every edge.
      for (int i = 0; i < 3000; i++) begin
         @(negedge board);
         if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
         @(posedge board);
         #1;
         check_model("rand");
         if (rst_n && $urandom_range(0, 99) < 3) begin
            #($urandom_range(1, 2));
            rst_n = 1'b0;
            #1;
            check_model("rand_async");
         end
      end

      // Count 1000 board cycles after a fresh reset.
      @(negedge board);
      rst_n = 1'b0;
      @(negedge board);
      rst_n    = 1'b1;
      n_rise   = 0;
      n_pulse2 = 0;
      n_pulse5 = 0;
      prev_dc  = w_dc[0];
      repeat (1000) begin
         @(posedge board);
         #1;
         if (w_dc[0] && !prev_dc) n_rise++;
         prev_dc = w_dc[0];
         if (w_en[0]) n_pulse2++;
         if (w_en[3]) n_pulse5++;
      end
      n_chk++;
      if (n_rise != 500) begin
         n_err++;
         $display("FAIL count_rise_div2: got %0d, expected 500", n_rise);
      end
      n_chk++;
      if (n_pulse2 != 500) begin
         n_err++;
         $display("FAIL count_en_div2: got %0d, expected 500", n_pulse2);
      end
      n_chk++;
      if (n_pulse5 != 200) begin
         n_err++;
         $display("FAIL count_en_div5: got %0d, expected 200", n_pulse5);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

endmodule
